// File: rtl/fp80_decomp_arb.sv
// Round-robin arbiter sharing one registered FP80 decompose stage, with locked a/b pairs.
// Optional build macro FP80_DECOMP_ARB_STATS_EN adds saturating nan/inf/zero counters.
module fp80_decomp_arb #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_pair,
  input  logic [NREQ*80-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [TAGW-1:0]    o_tag,
  output logic               o_first,
  output logic               o_last,
  output logic [79:0]        o_raw,
  output logic               o_sgn,
  output logic [14:0]        o_exp,
  output logic [63:0]        o_man,
  output logic [64:0]        o_fract,
  output logic               o_xz,
  output logic               o_mz,
  output logic               o_vz,
  output logic               o_inf,
  output logic               o_xinf,
  output logic               o_qnan,
  output logic               o_snan,
  output logic               o_nan
`ifdef FP80_DECOMP_ARB_STATS_EN
  , input  logic             stat_clr
  , output logic [15:0]      stat_nan
  , output logic [15:0]      stat_inf
  , output logic [15:0]      stat_zero
`endif
);

  // state | meaning
  // IDLE  | round-robin grant of the next single op or first beat of a pair
  // LOCK  | only owner_q may transfer; waiting for the second beat of its pair
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [TAGW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [TAGW-1:0] g_hi, g_lo, grant, sel, sel_inc;
  logic            found_hi, found_lo, accept, grant_ok, pair_sel, xfer;
  logic [79:0]     sel_data;
  logic [14:0]     d_e;
  logic [63:0]     d_s;
  logic [7:0]      d_flags;

  logic            o_valid_q, o_valid_d, first_q, first_d, last_q, last_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [79:0]     raw_q, raw_d;
  logic [7:0]      flags_q, flags_d;

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    g_hi     = '0;
    g_lo     = '0;
    // Wrap-around scan: first valid at/after the pointer, else first valid overall.
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[k]) begin
        if (!found_hi && (TAGW'(k) >= rr_ptr_q)) begin
          found_hi = 1'b1;
          g_hi     = TAGW'(k);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          g_lo     = TAGW'(k);
        end
      end
    end
    grant = found_hi ? g_hi : g_lo;
  end

  always_comb begin
    accept   = ce & rst_n & (~o_valid_q | o_ready);
    sel      = (state_q == LOCK) ? owner_q : grant;
    grant_ok = (state_q == LOCK) ? 1'b1 : found_lo;
    sel_inc  = (sel == TAGW'(NREQ - 1)) ? '0 : sel + TAGW'(1);
    req_ready = '0;
    sel_data  = '0;
    pair_sel  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (TAGW'(k) == sel) begin
        req_ready[k] = accept & grant_ok;
        sel_data     = req_data[80*k +: 80];
        pair_sel     = req_pair[k];
      end
    end
    xfer = |(req_valid & req_ready);

    d_e = sel_data[78:64];
    d_s = sel_data[63:0];
    d_flags = {(d_e == '0), (d_s == '0), (d_e == '0) & (d_s == '0),
               (&d_e) & (d_s == '0), (&d_e), (&d_e) & d_s[63],
               (&d_e) & ~d_s[63] & (d_s != '0), (&d_e) & (d_s != '0)};

    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    o_valid_d = o_valid_q & ~o_ready;
    tag_d     = tag_q;
    first_d   = first_q;
    last_d    = last_q;
    raw_d     = raw_q;
    flags_d   = flags_q;
    if (xfer) begin
      o_valid_d = 1'b1;
      tag_d     = sel;
      raw_d     = sel_data;
      flags_d   = d_flags;
      if (state_q == IDLE) begin
        first_d = 1'b1;
        last_d  = ~pair_sel;
        if (pair_sel) begin
          state_d = LOCK;
          owner_d = sel;
        end else begin
          rr_ptr_d = sel_inc;
        end
      end else begin
        first_d  = 1'b0;
        last_d   = 1'b1;
        rr_ptr_d = sel_inc;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      o_valid_q <= 1'b0;
      tag_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      raw_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      o_valid_q <= o_valid_d;
      tag_q     <= tag_d;
      first_q   <= first_d;
      last_q    <= last_d;
      raw_q     <= raw_d;
      flags_q   <= flags_d;
    end
  end

  // Field splits are plain wiring off the registered operand; all zero in reset.
  assign o_valid = o_valid_q;
  assign o_tag   = tag_q;
  assign o_first = first_q;
  assign o_last  = last_q;
  assign o_raw   = raw_q;
  assign o_sgn   = raw_q[79];
  assign o_exp   = raw_q[78:64];
  assign o_man   = raw_q[63:0];
  assign o_fract = {(|raw_q[78:64]), raw_q[63:0]};
  assign {o_xz, o_mz, o_vz, o_inf, o_xinf, o_qnan, o_snan, o_nan} = flags_q;

`ifdef FP80_DECOMP_ARB_STATS_EN
  logic [15:0] stat_nan_q, stat_nan_d, stat_inf_q, stat_inf_d, stat_zero_q, stat_zero_d;

  always_comb begin
    stat_nan_d  = stat_nan_q;
    stat_inf_d  = stat_inf_q;
    stat_zero_d = stat_zero_q;
    if (stat_clr) begin
      stat_nan_d  = '0;
      stat_inf_d  = '0;
      stat_zero_d = '0;
    end else if (xfer) begin
      if (d_flags[0] && !(&stat_nan_q))  stat_nan_d  = stat_nan_q + 16'd1;
      if (d_flags[4] && !(&stat_inf_q))  stat_inf_d  = stat_inf_q + 16'd1;
      if (d_flags[5] && !(&stat_zero_q)) stat_zero_d = stat_zero_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_nan_q  <= '0;
      stat_inf_q  <= '0;
      stat_zero_q <= '0;
    end else begin
      stat_nan_q  <= stat_nan_d;
      stat_inf_q  <= stat_inf_d;
      stat_zero_q <= stat_zero_d;
    end
  end

  assign stat_nan  = stat_nan_q;
  assign stat_inf  = stat_inf_q;
  assign stat_zero = stat_zero_q;
`endif

endmodule
